prio_event_encoder: RTL and testbench



---
 rtl/prio_enc_pkg.sv | 8 +
 rtl/prio_event_encoder_pick.sv | 31 +++
 rtl/prio_event_encoder.sv | 68 ++++++
 tb/tb_prio_event_encoder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared edge-mode constants and index-width helper for prio_event_encoder.
package prio_enc_pkg;
   localparam int EDGE_LEVEL = 0;
   localparam int EDGE_RISE  = 1;
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/prio_event_encoder_pick.sv
// prio_pick: combinational find-first-set starting at a pointer, wrapping from N-1 to 0.
module prio_pick #(
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     vec,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);
   int               j;
   logic [IDX_W-1:0] p;
   // Scan farthest-first so the hit nearest the start pointer is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      j     = 0;
      p     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = int'(start) + i;
         j = (j >= N) ? j - N : j;
         p = IDX_W'(j);
         if (vec[p]) begin
            found = 1'b1;
            idx   = p;
         end
      end
      onehot = found ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/prio_event_encoder.sv
// prio_event_encoder: registered priority encoder with pending latches, masking and valid/ready output.
// Define PRIO_ROTATE_EN for round-robin priority; otherwise fixed priority with index 0 highest.
module prio_event_encoder
   import prio_enc_pkg::*;
#(
   parameter int  N     = 8,
   parameter int  EDGE  = EDGE_LEVEL,
   localparam int IDX_W = idx_width(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     mask,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   input  logic             out_ready,
   output logic [N-1:0]     pending,
   output logic             any_req
);
   logic [N-1:0]     req_d, set_v, clr, elig, pick_oh, out_oh;
   logic [IDX_W-1:0] start, pick_idx;
   logic             hs, load, found;

   assign hs      = out_valid & out_ready;
   assign set_v   = (EDGE == EDGE_RISE) ? (req & ~req_d) : req;
   assign clr     = hs ? out_oh : '0;
   assign elig    = pending & ~mask & ~clr;
   assign load    = ~out_valid | hs;
   assign any_req = |(pending & ~mask);

`ifdef PRIO_ROTATE_EN
   logic [IDX_W-1:0] ptr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (hs) ptr <= (out_idx == IDX_W'(N - 1)) ? '0 : out_idx + 1'b1;
   assign start = ptr;
`else
   assign start = '0;
`endif

   prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
      .vec(elig),
      .start(start),
      .found(found),
      .idx(pick_idx),
      .onehot(pick_oh)
   );

   // Set wins over clear on the same bit so a capture during its own handshake is kept.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         req_d     <= '0;
         pending   <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_oh    <= '0;
      end else begin
         req_d   <= req;
         pending <= (pending & ~clr) | set_v;
         if (load) begin
            out_valid <= found;
            if (found) begin
               out_idx <= pick_idx;
               out_oh  <= pick_oh;
            end
         end
      end
endmodule

// File: tb/tb_prio_event_encoder.sv
// tb_prio_event_encoder: level, rising-edge and N=6 instances checked against a rule-level model.
module tb_prio_event_encoder;
`ifdef PRIO_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif
   localparam int NN[3] = '{8, 8, 6};
   localparam int EE[3] = '{0, 1, 1};

   typedef struct packed {
      logic [63:0] pend;
      logic [63:0] rd;
      logic        v;
      logic [5:0]  idx;
      logic [5:0]  ptr;
   } st_t;

   logic       clk = 1'b0, rst_n = 1'b0, rdy = 1'b0;
   logic [7:0] req = '0, mask = '0;
   logic       lv_v, lv_a, rs_v, rs_a, sx_v, sx_a;
   logic [2:0] lv_i, rs_i, sx_i;
   logic [7:0] lv_p, rs_p;
   logic [5:0] sx_p;
   int         n_chk = 0, n_fail = 0;
   st_t        ms[3];

   always #10 clk = ~clk;

   prio_event_encoder #(.N(8), .EDGE(0)) u_lvl (
      .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .out_valid(lv_v),
      .out_idx(lv_i), .out_ready(rdy), .pending(lv_p), .any_req(lv_a));
   prio_event_encoder #(.N(8), .EDGE(1)) u_rise (
      .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .out_valid(rs_v),
      .out_idx(rs_i), .out_ready(rdy), .pending(rs_p), .any_req(rs_a));
   prio_event_encoder #(.N(6), .EDGE(1)) u_six (
      .clk(clk), .rst_n(rst_n), .req(req[5:0]), .mask(mask[5:0]), .out_valid(sx_v),
      .out_idx(sx_i), .out_ready(rdy), .pending(sx_p), .any_req(sx_a));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Next state from the rules: capture, clear on handshake, reload idle/accepted output.
   function automatic st_t step(st_t s, logic [63:0] r, logic [63:0] m, logic rd_y, int n, int em);
      st_t         t   = s;
      logic [63:0] lim = (n >= 64) ? '1 : (64'd1 << n) - 64'd1;
      logic [63:0] clr = '0;
      logic [63:0] el;
      bit          hs  = s.v && rd_y;
      int          st  = ROT ? int'(s.ptr) : 0;
      r = r & lim;
      if (hs) clr[s.idx] = 1'b1;
      t.rd   = r;
      t.pend = (s.pend & ~clr) | ((em == 1) ? (r & ~s.rd) : r);
      el     = s.pend & ~m & ~clr & lim;
      if (hs && ROT) t.ptr = 6'((int'(s.idx) + 1) % n);
      if (!s.v || hs) begin
         t.v = 1'b0;
         for (int k = 0; k < n; k++)
            if (!t.v && el[(st + k) % n]) begin
               t.v   = 1'b1;
               t.idx = 6'((st + k) % n);
            end
      end
      return t;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) for (int k = 0; k < 3; k++) ms[k] <= '0;
      else for (int k = 0; k < 3; k++) ms[k] <= step(ms[k], 64'(req), 64'(mask), rdy, NN[k], EE[k]);

   task automatic cmp(input string nm, input int k, input logic v, input logic [5:0] ix,
                      input logic [63:0] pd, input logic ar);
      logic [63:0] lim = (64'd1 << NN[k]) - 64'd1;
      chk({nm, ".valid"}, 64'(v), 64'(ms[k].v));
      chk({nm, ".idx"}, 64'(ix), 64'(ms[k].idx));
      chk({nm, ".pending"}, pd, ms[k].pend);
      chk({nm, ".any_req"}, 64'(ar), 64'(|(ms[k].pend & ~64'(mask) & lim)));
   endtask

   always @(negedge clk)
      if (rst_n) begin
         cmp("lvl", 0, lv_v, 6'(lv_i), 64'(lv_p), lv_a);
         cmp("rise", 1, rs_v, 6'(rs_i), 64'(rs_p), rs_a);
         cmp("six", 2, sx_v, 6'(sx_i), 64'(sx_p), sx_a);
      end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      // fixed-order issue of a one-cycle burst
      rdy = 1'b1; req = 8'hA0;
      tick; req = 8'h00;
      @(negedge clk); chk("burst_pend", 64'(rs_p), 64'hA0);
      tick; @(negedge clk); chk("burst_v1", 64'(rs_v), 64'd1); chk("burst_i1", 64'(rs_i), 64'd5);
      tick; @(negedge clk); chk("burst_v2", 64'(rs_v), 64'd1); chk("burst_i2", 64'(rs_i), 64'd7);
      tick; @(negedge clk); chk("burst_v3", 64'(rs_v), 64'd0); chk("burst_p3", 64'(rs_p), 64'h00);
      // masked pending bit survives while the other one issues
      tick; req = 8'h81; mask = 8'h01;
      tick; req = 8'h00;
      @(negedge clk); chk("mask_any0", 64'(lv_a), 64'd1);
      tick; @(negedge clk); chk("mask_i7", 64'(lv_i), 64'd7); chk("mask_v7", 64'(lv_v), 64'd1);
      tick; @(negedge clk); chk("mask_any1", 64'(lv_a), 64'd0); chk("mask_p1", 64'(lv_p), 64'h01);
      chk("mask_v1", 64'(lv_v), 64'd0);
      tick; mask = 8'h00;
      @(negedge clk); chk("mask_any2", 64'(lv_a), 64'd1);
      tick; @(negedge clk); chk("unmask_v", 64'(lv_v), 64'd1); chk("unmask_i", 64'(lv_i), 64'd0);
      // backpressure holds the output while mask changes
      tick; rdy = 1'b0; req = 8'h06;
      tick; req = 8'h00;
      tick; mask = 8'h02;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); chk("hold_v", 64'(lv_v), 64'd1); chk("hold_i", 64'(lv_i), 64'd1);
         tick; mask = mask ^ 8'h02;
      end
      rdy = 1'b1; mask = 8'h00;
      tick; @(negedge clk); chk("bp_next", 64'(lv_i), 64'd2); chk("bp_nv", 64'(lv_v), 64'd1);
      tick; @(negedge clk); chk("bp_done", 64'(lv_v), 64'd0);
      // new rising edge during the handshake of the same index
      tick; req = 8'h10;
      tick; req = 8'h00;
      tick; req = 8'h10;
      @(negedge clk); chk("coll_i", 64'(rs_i), 64'd4); chk("coll_v", 64'(rs_v), 64'd1);
      tick; req = 8'h00;
      @(negedge clk); chk("coll_pend", 64'(rs_p[4]), 64'd1); chk("coll_gap", 64'(rs_v), 64'd0);
      tick; @(negedge clk); chk("coll_reissue", 64'(rs_i), 64'd4); chk("coll_rv", 64'(rs_v), 64'd1);
      tick; @(negedge clk); chk("coll_clear", 64'(rs_p), 64'h00);
      // level mode with two held requests: the just-accepted bit sits out one load
      tick; req = 8'h41;
      tick; tick;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("lvl_alt", 64'(lv_i), ((i + int'(ROT)) % 2 == 0) ? 64'd0 : 64'd6);
         tick;
      end
      req = 8'h00;
      repeat (4) tick;
      // asynchronous reset in the middle of a held output
      rdy = 1'b0; req = 8'h08;
      tick; req = 8'h00;
      tick; @(negedge clk); chk("pre_rst_v", 64'(lv_v), 64'd1); chk("pre_rst_i", 64'(lv_i), 64'd3);
      tick; #1 rst_n = 1'b0;
      #1 chk("rst_v", 64'(lv_v), 64'd0); chk("rst_i", 64'(lv_i), 64'd0); chk("rst_p", 64'(lv_p), 64'h00);
      chk("rst_rv", 64'(rs_v), 64'd0);
      #2 rst_n = 1'b1;
      @(negedge clk); chk("post_rst_v", 64'(lv_v), 64'd0); chk("post_rst_p", 64'(lv_p), 64'h00);
      tick; @(negedge clk); chk("post_rst_v2", 64'(lv_v), 64'd0);
      // random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         tick;
         req  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         mask = ($urandom_range(0, 7) == 0) ? 8'($urandom & $urandom) : mask;
         rdy  = ($urandom_range(0, 3) != 0);
      end
      req = 8'h00; mask = 8'h00; rdy = 1'b1;
      repeat (20) tick;
      @(negedge clk); chk("drain_v", 64'(lv_v), 64'd0); chk("drain_p", 64'(rs_p), 64'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
